// File: rtl/sdram_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_pll_lock_sequencer
//
// Purpose:
//   Runs on the PLL reference clock. It takes the PLL's asynchronous locked
//   flag and produces an ordered bring-up sequence for the SDRAM controller:
//     1. synchronise pll_locked,
//     2. require the lock to stay high for LOCK_STABLE_CYCLES,
//     3. release the controller reset and wait PWRUP_CYCLES,
//     4. hold init_req until the controller reports init_done,
//     5. report ready and watch for lock loss.
//   Loss of lock after acceptance (PWRUP, INIT or RUN) returns to WAIT_LOCK and
//   bumps a saturating loss counter. If no lock arrives within
//   LOCK_TIMEOUT_CYCLES in WAIT_LOCK, the sticky lock_timeout flag is set.
//
// Optional feature (compile-time macro PLL_AUTO_RESET_EN):
//   Defined   - a WAIT_LOCK timeout also moves to PLL_RST, which drives
//               pll_rst high for PLL_RST_CYCLES cycles and then returns to
//               WAIT_LOCK with a fresh timeout window.
//   Undefined - PLL_RST is never entered and pll_rst is constant 0; after a
//               timeout the FSM keeps waiting for lock.
//
// Ports:
//   refclk       in   sequencer clock
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock flag (asynchronous to refclk)
//   init_done    in   SDRAM controller init complete (level)
//   sdram_rst    out  active-high reset to the SDRAM controller
//   init_req     out  init request, held until init_done
//   ready        out  SDRAM path up and locked
//   lock_timeout out  sticky lock timeout flag
//   loss_cnt     out  saturating count of lock-loss events
//   pll_rst      out  PLL reset pulse (optional feature)
//   state        out  FSM state encoding for debug
// -----------------------------------------------------------------------------
module sdram_pll_lock_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int PWRUP_CYCLES        = 10000,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       init_done,
    output logic       sdram_rst,
    output logic       init_req,
    output logic       ready,
    output logic       lock_timeout,
    output logic [7:0] loss_cnt,
    output logic       pll_rst,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        PWRUP     = 3'd2,
        INIT      = 3'd3,
        RUN       = 3'd4,
        PLL_RST   = 3'd5
    } state_t;

    // Counter reload values: each phase lasts exactly <N> cycles because the
    // counter is loaded with N-1 on entry and the exit happens when it reads 0.
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRUP_LOAD   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLLRST_LOAD  = CNT_W'(PLL_RST_CYCLES - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_timeout_reg;
    logic [7:0]             loss_cnt_reg;
    logic                   lock_s;
    logic                   timeout_hit;
    logic                   loss_event;

    // Plain shift-register synchroniser; only the last stage is ever used.
    assign lock_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State register and the registered side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg        <= WAIT_LOCK;
            cnt_reg          <= TIMEOUT_LOAD;
            sync_reg         <= '0;
            lock_timeout_reg <= 1'b0;
            loss_cnt_reg     <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
            if (timeout_hit) begin
                lock_timeout_reg <= 1'b1;
            end
            if (loss_event && (loss_cnt_reg != 8'hFF)) begin
                loss_cnt_reg <= loss_cnt_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Lock loss is tested first in the post-acceptance
    // states so it wins over counter expiry and init_done in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : cnt_reg;
        timeout_hit = 1'b0;
        loss_event  = 1'b0;
        unique case (state_reg)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = STABLE_LOAD;
                end else if (cnt_reg == '0) begin
                    timeout_hit = 1'b1;
`ifdef PLL_AUTO_RESET_EN
                    state_next  = PLL_RST;
                    cnt_next    = PLLRST_LOAD;
`else
                    // Keep waiting; the flag is sticky so restarting the
                    // window has no visible effect.
                    cnt_next    = TIMEOUT_LOAD;
`endif
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    // Glitch before acceptance: not counted as a loss.
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = PWRUP;
                    cnt_next   = PWRUP_LOAD;
                end
            end
            PWRUP: begin
                if (!lock_s) begin
                    loss_event = 1'b1;
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            INIT: begin
                if (!lock_s) begin
                    loss_event = 1'b1;
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end else if (init_done) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss_event = 1'b1;
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end
            end
            PLL_RST: begin
                // lock_s deliberately ignored while the PLL is held in reset.
                if (cnt_reg == '0) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = TIMEOUT_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, from the state register)
    // ------------------------------------------------------------------
    always_comb begin
        sdram_rst = 1'b1;
        init_req  = 1'b0;
        ready     = 1'b0;
        pll_rst   = 1'b0;
        unique case (state_reg)
            PWRUP: sdram_rst = 1'b0;
            INIT: begin
                sdram_rst = 1'b0;
                init_req  = 1'b1;
            end
            RUN: begin
                sdram_rst = 1'b0;
                ready     = 1'b1;
            end
            PLL_RST: begin
`ifdef PLL_AUTO_RESET_EN
                pll_rst = 1'b1;
`else
                pll_rst = 1'b0;
`endif
            end
            default: begin
                sdram_rst = 1'b1;
            end
        endcase
    end

    assign lock_timeout = lock_timeout_reg;
    assign loss_cnt     = loss_cnt_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_sdram_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdram_pll_lock_sequencer
//
// Self-checking bench for sdram_pll_lock_sequencer with short simulation
// parameters. A behavioural model (phase + elapsed-cycle count, delayed lock
// history) predicts every output each cycle; directed sections check bring-up
// latency, timeout, loss/init_done collision, saturation and reset.
// Honours PLL_AUTO_RESET_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sdram_pll_lock_sequencer;

    localparam int SYNC   = 2;
    localparam int LSC    = 8;
    localparam int PWR    = 20;
    localparam int TMO    = 50;
    localparam int PRC    = 4;

    localparam int P_WAIT   = 0;
    localparam int P_STABLE = 1;
    localparam int P_PWRUP  = 2;
    localparam int P_INIT   = 3;
    localparam int P_RUN    = 4;
    localparam int P_PLLRST = 5;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       init_done = 1'b0;
    logic       sdram_rst, init_req, ready, lock_timeout, pll_rst;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int m_phase   = P_WAIT;
    int m_elapsed = 0;
    int m_loss    = 0;
    bit m_to      = 1'b0;
    bit m_sync [SYNC];

    sdram_pll_lock_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .PWRUP_CYCLES       (PWR),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .PLL_RST_CYCLES     (PRC),
        .CNT_W              (17)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .init_done   (init_done),
        .sdram_rst   (sdram_rst),
        .init_req    (init_req),
        .ready       (ready),
        .lock_timeout(lock_timeout),
        .loss_cnt    (loss_cnt),
        .pll_rst     (pll_rst),
        .state       (state)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Enter a phase: the elapsed count restarts.
    task automatic m_goto(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    task automatic m_lose();
        if (m_loss < 255) m_loss++;
        m_goto(P_WAIT);
    endtask

    // One rising edge of the model, using the inputs the DUT sampled.
    task automatic model_edge();
        bit ls;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            m_goto(P_WAIT);
            m_loss = 0;
            m_to   = 1'b0;
            return;
        end
        ls = m_sync[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = pll_locked;
        case (m_phase)
            P_WAIT: begin
                if (ls) m_goto(P_STABLE);
                else if (m_elapsed + 1 == TMO) begin
                    m_to = 1'b1;
`ifdef PLL_AUTO_RESET_EN
                    m_goto(P_PLLRST);
`else
                    m_goto(P_WAIT);
`endif
                end else m_elapsed++;
            end
            P_STABLE: begin
                if (!ls) m_goto(P_WAIT);
                else if (m_elapsed + 1 == LSC) m_goto(P_PWRUP);
                else m_elapsed++;
            end
            P_PWRUP: begin
                if (!ls) m_lose();
                else if (m_elapsed + 1 == PWR) m_goto(P_INIT);
                else m_elapsed++;
            end
            P_INIT: begin
                if (!ls) m_lose();
                else if (init_done) m_goto(P_RUN);
            end
            P_RUN: begin
                if (!ls) m_lose();
            end
            default: begin
                if (m_elapsed + 1 == PRC) m_goto(P_WAIT);
                else m_elapsed++;
            end
        endcase
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
        check("state", 32'(state), 32'(m_phase));
        check("sdram_rst", 32'(sdram_rst),
              32'(m_phase == P_WAIT || m_phase == P_STABLE || m_phase == P_PLLRST));
        check("init_req", 32'(init_req), 32'(m_phase == P_INIT));
        check("ready", 32'(ready), 32'(m_phase == P_RUN));
        check("pll_rst", 32'(pll_rst), 32'(m_phase == P_PLLRST));
        check("lock_timeout", 32'(lock_timeout), 32'(m_to));
        check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    // Tick until the model reaches phase p; an expired bound is a failure.
    task automatic run_until(input int p, input int bound, input string tag);
        int k;
        k = 0;
        while (m_phase != p && k < bound) begin
            tick();
            k++;
        end
        check({tag, "_reached"}, 32'(m_phase == p), 32'd1);
    endtask

    initial begin
        int n;
        int kind;
        int len;

        // ---------------- reset state ----------------
        do_reset(4);
        check("reset_state", 32'(state), 32'd0);
        check("reset_sdram_rst", 32'(sdram_rst), 32'd1);
        $display("reset: state=%0d sdram_rst=%0d", state, sdram_rst);

        // ---------------- clean bring-up ----------------
        for (int i = 0; i < 5; i++) tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (sdram_rst && n < 100);
        // Sampling edge counted as 1: SYNC edges to reach lock_s, LSC in STABLE.
        check("bringup_rst_lat", 32'(n), 32'(SYNC + LSC + 1));
        n = 0;
        do begin tick(); n++; end while (!init_req && n < 100);
        check("bringup_pwrup_lat", 32'(n), 32'(PWR));
        for (int i = 0; i < 5; i++) tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        check("bringup_ready", 32'(ready), 32'd1);
        check("bringup_loss", 32'(loss_cnt), 32'd0);
        $display("bring-up: rst latency ok, ready=%0d loss_cnt=%0d", ready, loss_cnt);

        // ---------------- loss in RUN, then full relock ----------------
        pll_locked = 1'b0;
        for (int i = 0; i < SYNC + 1; i++) tick();
        check("run_loss_state", 32'(state), 32'd0);
        check("run_loss_cnt", 32'(loss_cnt), 32'd1);
        pll_locked = 1'b1;
        run_until(P_PWRUP, 40, "relock_pwrup");
        run_until(P_INIT, 40, "relock_init");
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        $display("loss in RUN: loss_cnt=%0d ready=%0d after relock", loss_cnt, ready);

        // ---------------- glitchy lock ----------------
        do_reset(2);
        pll_locked = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (sdram_rst && n < 100);
        check("glitch_lat", 32'(n), 32'(SYNC + LSC + 1));
        check("glitch_loss", 32'(loss_cnt), 32'd0);
        $display("glitchy lock: accepted after %0d edges, loss_cnt=%0d", n, loss_cnt);

        // ---------------- loss and init_done together in INIT ----------------
        run_until(P_INIT, 40, "collide_init");
        pll_locked = 1'b0;
        tick();
        tick();
        init_done = 1'b1;          // lock_s is now 0: both seen on the next edge
        tick();
        init_done = 1'b0;
        check("collide_ready", 32'(ready), 32'd0);
        check("collide_state", 32'(state), 32'd0);
        check("collide_loss", 32'(loss_cnt), 32'd1);
        $display("loss+init_done in INIT: state=%0d loss_cnt=%0d", state, loss_cnt);

        // ---------------- timeout ----------------
        do_reset(2);
        for (int i = 0; i < TMO - 1; i++) tick();
        check("timeout_early", 32'(lock_timeout), 32'd0);
        tick();
        check("timeout_set", 32'(lock_timeout), 32'd1);
        for (int i = 0; i < 3 * (TMO + PRC); i++) tick();
        $display("timeout: lock_timeout=%0d state=%0d", lock_timeout, state);

        // ---------------- rst during PWRUP ----------------
        pll_locked = 1'b1;
        run_until(P_PWRUP, 60, "rst_pwrup");
        tick();
        do_reset(1);
        check("rst_pwrup_state", 32'(state), 32'd0);
        check("rst_pwrup_timeout", 32'(lock_timeout), 32'd0);
        $display("rst in PWRUP: state=%0d sdram_rst=%0d", state, sdram_rst);

        // ---------------- randomized segments ----------------
        for (int seg = 0; seg < 150; seg++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                pll_locked = 1'b0; len = int'($urandom_range(40, 70));
            end else if (kind <= 3) begin
                pll_locked = 1'b0; len = int'($urandom_range(1, 6));
            end else begin
                pll_locked = 1'b1; len = int'($urandom_range(5, 60));
            end
            for (int i = 0; i < len; i++) begin
                init_done = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
            rst = 1'b0;
            $display("seg %0d: lock=%0b len=%0d state=%0d loss_cnt=%0d", seg, pll_locked, len, state, loss_cnt);
        end
        init_done = 1'b0;

        // ---------------- loss counter saturation ----------------
        do_reset(2);
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b1;
            run_until(P_PWRUP, 40, "sat_up");
            pll_locked = 1'b0;
            run_until(P_WAIT, 10, "sat_down");
        end
        check("loss_sat", 32'(loss_cnt), 32'd255);
        $display("saturation: loss_cnt=%0d after 260 losses", loss_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
